// File: rtl/uart_inst_loader_pkg.sv
// Shared types for the UART instruction loader: FSM state encoding and default image limit.
package uart_loader_pkg;
  localparam int MAX_INST_DEF = 1024;

  typedef enum logic [2:0] {
    S_CNT_HI,
    S_CNT_LO,
    S_INST_HI,
    S_INST_LO,
    S_CHK,
    S_FIN,
    S_DONE,
    S_ERR
  } state_t;
endpackage

// File: rtl/uart_inst_loader_if.sv
// Loader bus: raw UART bytes in, assembled instruction words and load status out.
interface uart_inst_loader_if #(
  parameter int ADDR_W = 16
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rearm;
  logic [15:0]       uart_inst;
  logic              uart_inst_en;
  logic [ADDR_W-1:0] inst_addr;
  logic              cpu_enable;
  logic              done;
  logic              load_err;

  modport master (
    input  rx_data, rx_valid, rearm,
    output uart_inst, uart_inst_en, inst_addr, cpu_enable, done, load_err
  );

  modport slave (
    output rx_data, rx_valid, rearm,
    input  uart_inst, uart_inst_en, inst_addr, cpu_enable, done, load_err
  );
endinterface

// File: rtl/uart_inst_loader_byte_pair.sv
// Big-endian byte pairing: holds the high byte, presents {hi, lo} while the low byte is on the bus.
module uart_byte_pair (
  input  logic        clk,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [7:0]  byte_in,
  output logic [15:0] word,
  output logic        word_vld
);
  logic [7:0] hi_q;

  // High byte is always rewritten before it is used, so it carries no reset.
  always_ff @(posedge clk) begin
    if (hi_we) hi_q <= byte_in;
  end

  assign word     = {hi_q, byte_in};
  assign word_vld = lo_we;
endmodule

// File: rtl/uart_inst_loader.sv
// UART instruction loader: COUNT header then COUNT big-endian 16-bit words to the fetch stage.
// Optional trailing XOR checksum byte enabled by defining UART_LOADER_CHECKSUM_EN.
module uart_inst_loader
  import uart_loader_pkg::*;
#(
  parameter int MAX_INST = MAX_INST_DEF,
  parameter int ADDR_W   = 16
) (
  input  logic                clk,
  input  logic                reset,
  uart_inst_loader_if.master  bus
);
  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] index;
  logic              hi_we;
  logic              lo_we;
  logic [15:0]       pair_word;
  logic              pair_vld;

`ifdef UART_LOADER_CHECKSUM_EN
  localparam state_t S_END = S_CHK;
  logic [7:0] chk;
`else
  localparam state_t S_END = S_FIN;
`endif

  assign hi_we = bus.rx_valid && (state == S_CNT_HI || state == S_INST_HI);
  assign lo_we = bus.rx_valid && (state == S_CNT_LO || state == S_INST_LO);

  uart_byte_pair u_pair (
    .clk      (clk),
    .hi_we    (hi_we),
    .lo_we    (lo_we),
    .byte_in  (bus.rx_data),
    .word     (pair_word),
    .word_vld (pair_vld)
  );

  // Count and index are fully rewritten at COUNT_LO before any use.
  always_ff @(posedge clk) begin
    if (pair_vld && state == S_CNT_LO) begin
      cnt   <= ADDR_W'(pair_word);
      index <= '0;
    end else if (pair_vld && state == S_INST_LO) begin
      index <= index + 1'b1;
    end
  end

`ifdef UART_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (hi_we && state == S_CNT_HI) chk <= bus.rx_data;
    else if (hi_we || lo_we)        chk <= chk ^ bus.rx_data;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= S_CNT_HI;
      bus.uart_inst    <= '0;
      bus.uart_inst_en <= 1'b0;
      bus.inst_addr    <= '0;
      bus.cpu_enable   <= 1'b0;
      bus.done         <= 1'b0;
      bus.load_err     <= 1'b0;
    end else begin
      bus.uart_inst_en <= 1'b0;
      bus.done         <= 1'b0;
      unique case (state)
        S_CNT_HI: if (hi_we) state <= S_CNT_LO;
        S_CNT_LO: begin
          if (pair_vld) begin
            // Full 16-bit compare so headers above MAX_INST never alias into range.
            if (int'(pair_word) > MAX_INST) begin
              state        <= S_ERR;
              bus.load_err <= 1'b1;
            end else if (pair_word == 16'd0) begin
              state <= S_END;
            end else begin
              state <= S_INST_HI;
            end
          end
        end
        S_INST_HI: if (hi_we) state <= S_INST_LO;
        S_INST_LO: begin
          if (pair_vld) begin
            bus.uart_inst    <= pair_word;
            bus.inst_addr    <= index;
            bus.uart_inst_en <= 1'b1;
            state            <= (index + 1'b1 == cnt) ? S_END : S_INST_HI;
          end
        end
`ifdef UART_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (bus.rx_valid) begin
            if (bus.rx_data == chk) begin
              state <= S_FIN;
            end else begin
              state        <= S_ERR;
              bus.load_err <= 1'b1;
            end
          end
        end
`endif
        S_FIN: begin
          bus.done       <= 1'b1;
          bus.cpu_enable <= 1'b1;
          state          <= S_DONE;
        end
        S_DONE: begin
          if (bus.rearm) begin
            bus.cpu_enable <= 1'b0;
            bus.load_err   <= 1'b0;
            state          <= S_CNT_HI;
          end
        end
        S_ERR: begin
          if (bus.rearm) begin
            bus.load_err <= 1'b0;
            state        <= S_CNT_HI;
          end
        end
        default: state <= S_CNT_HI;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_inst_loader.sv
// Directed bench for uart_inst_loader: per-cycle vector table plus hand-written reset/boundary sequences.
module tb_uart_inst_loader;
  logic clk = 1'b0;
  logic reset = 1'b0;

`ifdef UART_LOADER_CHECKSUM_EN
  localparam bit CHK_ON = 1'b1;
`else
  localparam bit CHK_ON = 1'b0;
`endif

  uart_inst_loader_if #(.ADDR_W(16)) bus ();

  uart_inst_loader #(.MAX_INST(1024), .ADDR_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        rr;
    logic [35:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [35:0] outs();
    return {bus.uart_inst_en, bus.uart_inst, bus.inst_addr, bus.done, bus.cpu_enable, bus.load_err};
  endfunction

  task automatic cmp(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got en/inst/addr/done/cpu/err=%h required %h", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [7:0] d, input logic rr, input logic en,
                     input logic [15:0] inst, input logic [15:0] addr,
                     input logic dn, input logic cpu, input logic err);
    vec_t r;
    r.v   = v;
    r.d   = d;
    r.rr  = rr;
    r.exp = {en, inst, addr, dn, cpu, err};
    tbl.push_back(r);
  endtask

  // Checksum byte row: only present in the checksum build, outputs unchanged on that cycle.
  task automatic addchk(input logic [7:0] c, input logic [15:0] inst, input logic [15:0] addr,
                        input logic cpu);
    if (CHK_ON) add(1, c, 0, 0, inst, addr, 0, cpu, 0);
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic rr);
    bus.rx_valid = v;
    bus.rx_data  = d;
    bus.rearm    = rr;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    bus.rearm    = 1'b0;
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rearm    = 1'b0;

    // Two-word image 00 02 12 34 AB CD, then ignored bytes and rearm.
    add(1, 8'h00, 0, 0, 16'h0000, 16'd0, 0, 0, 0);
    add(1, 8'h02, 0, 0, 16'h0000, 16'd0, 0, 0, 0);
    add(1, 8'h12, 0, 0, 16'h0000, 16'd0, 0, 0, 0);
    add(1, 8'h34, 0, 1, 16'h1234, 16'd0, 0, 0, 0);
    add(1, 8'hAB, 0, 0, 16'h1234, 16'd0, 0, 0, 0);
    add(1, 8'hCD, 0, 1, 16'hABCD, 16'd1, 0, 0, 0);
    addchk(8'h42, 16'hABCD, 16'd1, 0);
    add(0, 8'h00, 0, 0, 16'hABCD, 16'd1, 1, 1, 0);
    add(0, 8'h00, 0, 0, 16'hABCD, 16'd1, 0, 1, 0);
    add(1, 8'hFF, 0, 0, 16'hABCD, 16'd1, 0, 1, 0);
    add(1, 8'hFF, 0, 0, 16'hABCD, 16'd1, 0, 1, 0);
    add(0, 8'h00, 1, 0, 16'hABCD, 16'd1, 0, 0, 0);
    // Empty image 00 00.
    add(1, 8'h00, 0, 0, 16'hABCD, 16'd1, 0, 0, 0);
    add(1, 8'h00, 0, 0, 16'hABCD, 16'd1, 0, 0, 0);
    addchk(8'h00, 16'hABCD, 16'd1, 0);
    add(0, 8'h00, 0, 0, 16'hABCD, 16'd1, 1, 1, 0);
    add(0, 8'h00, 1, 0, 16'hABCD, 16'd1, 0, 0, 0);
    // Oversize header 04 01, bytes ignored in error, rearm, then 00 01 00 07 with gaps.
    add(1, 8'h04, 0, 0, 16'hABCD, 16'd1, 0, 0, 0);
    add(1, 8'h01, 0, 0, 16'hABCD, 16'd1, 0, 0, 1);
    add(0, 8'h00, 0, 0, 16'hABCD, 16'd1, 0, 0, 1);
    add(1, 8'h00, 0, 0, 16'hABCD, 16'd1, 0, 0, 1);
    add(0, 8'h00, 1, 0, 16'hABCD, 16'd1, 0, 0, 0);
    add(1, 8'h00, 0, 0, 16'hABCD, 16'd1, 0, 0, 0);
    add(1, 8'h01, 0, 0, 16'hABCD, 16'd1, 0, 0, 0);
    add(0, 8'h00, 1, 0, 16'hABCD, 16'd1, 0, 0, 0);
    add(1, 8'h00, 0, 0, 16'hABCD, 16'd1, 0, 0, 0);
    add(0, 8'h00, 0, 0, 16'hABCD, 16'd1, 0, 0, 0);
    add(1, 8'h07, 0, 1, 16'h0007, 16'd0, 0, 0, 0);
    addchk(8'h06, 16'h0007, 16'd0, 0);
    add(0, 8'h00, 0, 0, 16'h0007, 16'd0, 1, 1, 0);
    add(0, 8'h00, 1, 0, 16'h0007, 16'd0, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    cmp("reset_state", outs(), 36'h0);
    reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].rr);
      cmp($sformatf("vec%0d", i), outs(), tbl[i].exp);
    end

    // Asynchronous reset in the middle of a word.
    step(1, 8'h00, 0);
    step(1, 8'h03, 0);
    step(1, 8'h11, 0);
    step(1, 8'h22, 0);
    cmp("mid_load_word", outs(), {1'b1, 16'h1122, 16'd0, 3'b000});
    step(1, 8'h33, 0);
    #2 reset = 1'b0;
    #1 cmp("async_reset", outs(), 36'h0);
    #3 reset = 1'b1;
    step(1, 8'h00, 0);
    step(1, 8'h01, 0);
    step(1, 8'h55, 0);
    step(1, 8'h66, 0);
    cmp("fresh_word", outs(), {1'b1, 16'h5566, 16'd0, 3'b000});
    if (CHK_ON) step(1, 8'h32, 0);
    step(0, 8'h00, 0);
    cmp("fresh_done", outs(), {1'b0, 16'h5566, 16'd0, 3'b110});

    // Header equal to MAX_INST is accepted and loading proceeds.
    step(0, 8'h00, 1);
    step(1, 8'h04, 0);
    step(1, 8'h00, 0);
    cmp("max_hdr_ok", outs(), {1'b0, 16'h5566, 16'd0, 3'b000});
    step(1, 8'h12, 0);
    step(1, 8'h34, 0);
    cmp("max_first_word", outs(), {1'b1, 16'h1234, 16'd0, 3'b000});
    step(0, 8'h00, 0);
    cmp("max_no_done", outs(), {1'b0, 16'h1234, 16'd0, 3'b000});
    #2 reset = 1'b0;
    #4 reset = 1'b1;

`ifdef UART_LOADER_CHECKSUM_EN
    step(1, 8'h00, 0);
    step(1, 8'h01, 0);
    step(1, 8'h12, 0);
    step(1, 8'h34, 0);
    step(1, 8'h27, 0);
    cmp("chk_good_pre", outs(), {1'b0, 16'h1234, 16'd0, 3'b000});
    step(0, 8'h00, 0);
    cmp("chk_good_done", outs(), {1'b0, 16'h1234, 16'd0, 3'b110});
    step(0, 8'h00, 1);
    step(1, 8'h00, 0);
    step(1, 8'h01, 0);
    step(1, 8'h12, 0);
    step(1, 8'h34, 0);
    step(1, 8'h00, 0);
    cmp("chk_bad_err", outs(), {1'b0, 16'h1234, 16'd0, 3'b001});
    step(0, 8'h00, 0);
    cmp("chk_bad_nodone", outs(), {1'b0, 16'h1234, 16'd0, 3'b001});
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
